multicycle_ctrl: RTL and testbench

Multicycle control sequencer for the MIPS datapath. It supports ADD, SUB, AND, OR, SLT, LW, SW and BEQ, and shares one ALU and one unified memory port across instruction phases. It drives the PC, IR, register file, ALU mux and memory enables state by state, and waits on a req/ready handshake to the memory. It sits between the instruction register decode fields and the datapath enables, and replaces the single-cycle control_decoder in the multicycle core.

---
 rtl/multicycle_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multicycle_ctrl : MIPS multicycle control FSM (ADD/SUB/AND/OR/SLT/LW/SW/BEQ) |
// | Optional macro ILLEGAL_OP_TRAP_EN: unknown opcodes trap instead of NOP.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             pc_src,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic [3:0]       state_out,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_R   = 4'd2;
  localparam logic [3:0] S_ALU_WB   = 4'd3;
  localparam logic [3:0] S_MEM_ADDR = 4'd4;
  localparam logic [3:0] S_MEM_RD   = 4'd5;
  localparam logic [3:0] S_MEM_WB   = 4'd6;
  localparam logic [3:0] S_MEM_WR   = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_TRAP     = 4'd9;

  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;

  localparam logic [2:0] C_ALU_AND = 3'b000;
  localparam logic [2:0] C_ALU_OR  = 3'b001;
  localparam logic [2:0] C_ALU_ADD = 3'b010;
  localparam logic [2:0] C_ALU_SUB = 3'b110;
  localparam logic [2:0] C_ALU_SLT = 3'b111;

  logic [3:0]       r_state;
  logic [CNT_W-1:0] r_count;
  logic [3:0]       w_next;
  logic             w_unused_zero;

  // The branch decision is made by the datapath from pc_write_cond and zero.
  assign w_unused_zero = zero;

  always_comb begin
    w_next        = r_state;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = C_ALU_AND;
    instr_done    = 1'b0;
    state_out     = r_state;

    case (r_state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = C_ALU_ADD;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = C_ALU_ADD;
        case (opcode)
          C_OP_RTYPE:        w_next = S_EXEC_R;
          C_OP_LW, C_OP_SW:  w_next = S_MEM_ADDR;
          C_OP_BEQ:          w_next = S_BRANCH;
          default: begin
`ifdef ILLEGAL_OP_TRAP_EN
            w_next = S_TRAP;
`else
            // Unknown opcode retires as a NOP; PC already advanced in FETCH.
            w_next     = S_FETCH;
            instr_done = 1'b1;
`endif
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        case (funct)
          6'b100000: alu_op = C_ALU_ADD;
          6'b100010: alu_op = C_ALU_SUB;
          6'b100100: alu_op = C_ALU_AND;
          6'b100101: alu_op = C_ALU_OR;
          6'b101010: alu_op = C_ALU_SLT;
          default:   alu_op = C_ALU_AND;
        endcase
        w_next = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = C_ALU_ADD;
        w_next    = (opcode == C_OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = C_ALU_SUB;
        pc_write_cond = 1'b1;
        pc_src        = 1'b1;
        instr_done    = 1'b1;
        w_next        = S_FETCH;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_FETCH;
    endcase

    // Reset gates every output so nothing is enabled before the state reg clears.
    if (!reset) begin
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      iord          = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_src        = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 3'b000;
      instr_done    = 1'b0;
      state_out     = 4'd0;
    end
  end

  assign instr_count = reset ? r_count : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (instr_done) r_count <= r_count + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// Bench for multicycle_ctrl: cycle vector table, reset/trap sequences and
// randomized instructions checked against an instruction-level model.
module tb_multicycle_ctrl;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [5:0]    opcode = '0, funct = '0;
  logic          zero = 1'b0, mem_ready = 1'b0;
  logic          mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src;
  logic          reg_write, reg_dst, mem_to_reg, alu_src_a, instr_done;
  logic [1:0]    alu_src_b;
  logic [2:0]    alu_op;
  logic [3:0]    state_out;
  logic [CW-1:0] instr_count;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_src(pc_src), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .state_out(state_out), .instr_done(instr_done),
    .instr_count(instr_count)
  );

  logic [16:0] w_ctl;
  assign w_ctl = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src,
                  reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, instr_done};

  // req we iord irw pcw pcwc pcsrc rw rdst m2r srca srcb aluop done
  localparam logic [16:0] C_FW  = 17'b1_0_0_0_0_0_0_0_0_0_0_01_010_0;
  localparam logic [16:0] C_FR  = 17'b1_0_0_1_1_0_0_0_0_0_0_01_010_0;
  localparam logic [16:0] C_DEC = 17'b0_0_0_0_0_0_0_0_0_0_0_11_010_0;
  localparam logic [16:0] C_EXA = 17'b0_0_0_0_0_0_0_0_0_0_1_00_010_0;
  localparam logic [16:0] C_EXS = 17'b0_0_0_0_0_0_0_0_0_0_1_00_111_0;
  localparam logic [16:0] C_AWB = 17'b0_0_0_0_0_0_0_1_1_0_0_00_000_1;
  localparam logic [16:0] C_MA  = 17'b0_0_0_0_0_0_0_0_0_0_1_10_010_0;
  localparam logic [16:0] C_MRD = 17'b1_0_1_0_0_0_0_0_0_0_0_00_000_0;
  localparam logic [16:0] C_MWB = 17'b0_0_0_0_0_0_0_1_0_1_0_00_000_1;
  localparam logic [16:0] C_MWR = 17'b1_1_1_0_0_0_0_0_0_0_0_00_000_1;
  localparam logic [16:0] C_BR  = 17'b0_0_0_0_0_1_1_0_0_0_1_00_110_1;

  typedef struct {
    logic [5:0]    op;
    logic [5:0]    fn;
    logic          mr;
    logic          z;
    logic [3:0]    st;
    logic [16:0]   ctl;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t          vecs[23];
  int            total = 0;
  int            bad = 0;
  logic [CW-1:0] exp_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] exp_alu(input logic [5:0] fn);
    case (fn)
      6'h20:   return 3'b010;
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2A:   return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  // Runs one instruction with fw fetch-wait and dw data-wait cycles; returns observed tallies.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int dw,
                           output int cyc, output int rq, output int we, output int rw);
    int  waits;
    bit  done;
    waits = fw; done = 0; cyc = 0; rq = 0; we = 0; rw = 0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      opcode = op; funct = fn; zero = 1'($urandom); mem_ready = 1'b0;
      #1;
      if (cyc == 0) begin
        chk("start_state", state_out, 0);
        chk("start_count", instr_count, exp_cnt);
      end
      if (mem_req) begin
        if (waits == 0) mem_ready = 1'b1;
        else waits--;
      end
      #1;
      if (state_out == 4'd2) chk("rand_alu_op", alu_op, exp_alu(fn));
      rq += int'(mem_req); we += int'(mem_we); rw += int'(reg_write);
      if (mem_req && mem_ready) waits = dw;
      if (instr_done) done = 1;
      cyc++;
    end
  endtask

  initial begin
    vecs[0]  = '{6'h00, 6'h20, 1'b1, 1'b0, 4'd0, C_FR,  4'd0};
    vecs[1]  = '{6'h00, 6'h20, 1'b0, 1'b0, 4'd1, C_DEC, 4'd0};
    vecs[2]  = '{6'h00, 6'h20, 1'b0, 1'b0, 4'd2, C_EXA, 4'd0};
    vecs[3]  = '{6'h00, 6'h20, 1'b0, 1'b0, 4'd3, C_AWB, 4'd0};
    vecs[4]  = '{6'h23, 6'h04, 1'b1, 1'b0, 4'd0, C_FR,  4'd1};
    vecs[5]  = '{6'h23, 6'h04, 1'b0, 1'b0, 4'd1, C_DEC, 4'd1};
    vecs[6]  = '{6'h23, 6'h04, 1'b0, 1'b0, 4'd4, C_MA,  4'd1};
    vecs[7]  = '{6'h23, 6'h04, 1'b0, 1'b0, 4'd5, C_MRD, 4'd1};
    vecs[8]  = '{6'h23, 6'h04, 1'b0, 1'b0, 4'd5, C_MRD, 4'd1};
    vecs[9]  = '{6'h23, 6'h04, 1'b1, 1'b0, 4'd5, C_MRD, 4'd1};
    vecs[10] = '{6'h23, 6'h04, 1'b0, 1'b0, 4'd6, C_MWB, 4'd1};
    vecs[11] = '{6'h2B, 6'h04, 1'b1, 1'b0, 4'd0, C_FR,  4'd2};
    vecs[12] = '{6'h2B, 6'h04, 1'b0, 1'b0, 4'd1, C_DEC, 4'd2};
    vecs[13] = '{6'h2B, 6'h04, 1'b0, 1'b0, 4'd4, C_MA,  4'd2};
    vecs[14] = '{6'h2B, 6'h04, 1'b1, 1'b0, 4'd7, C_MWR, 4'd2};
    vecs[15] = '{6'h04, 6'h04, 1'b1, 1'b1, 4'd0, C_FR,  4'd3};
    vecs[16] = '{6'h04, 6'h04, 1'b0, 1'b1, 4'd1, C_DEC, 4'd3};
    vecs[17] = '{6'h04, 6'h04, 1'b0, 1'b1, 4'd8, C_BR,  4'd3};
    vecs[18] = '{6'h00, 6'h2A, 1'b0, 1'b0, 4'd0, C_FW,  4'd4};
    vecs[19] = '{6'h00, 6'h2A, 1'b1, 1'b0, 4'd0, C_FR,  4'd4};
    vecs[20] = '{6'h00, 6'h2A, 1'b0, 1'b0, 4'd1, C_DEC, 4'd4};
    vecs[21] = '{6'h00, 6'h2A, 1'b0, 1'b0, 4'd2, C_EXS, 4'd4};
    vecs[22] = '{6'h00, 6'h2A, 1'b0, 1'b0, 4'd3, C_AWB, 4'd4};

    // Reset state, with mem_ready high to show it cannot leak through.
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ctl", w_ctl, 0);
    chk("rst_state", state_out, 0);
    chk("rst_count", instr_count, 0);
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b0;

    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      opcode = vecs[i].op; funct = vecs[i].fn; mem_ready = vecs[i].mr; zero = vecs[i].z;
      #1;
      chk($sformatf("vec%0d_state", i), state_out, vecs[i].st);
      chk($sformatf("vec%0d_ctl", i), w_ctl, vecs[i].ctl);
      chk($sformatf("vec%0d_count", i), instr_count, vecs[i].cnt);
    end

    // Reset asserted during a stalled LW read.
    @(negedge clk); opcode = 6'h23; mem_ready = 1'b1;
    #1 chk("mid_fetch_count", instr_count, 5);
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk); #1 chk("mid_memrd_req", mem_req, 1);
    @(negedge clk); reset = 1'b0;
    #1 chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_ctl", w_ctl, 0);
    @(negedge clk); reset = 1'b1;
    #1 chk("post_rst_state", state_out, 0);
    chk("post_rst_count", instr_count, 0);
    chk("post_rst_req", mem_req, 1);
    exp_cnt = '0;

    // Randomized instruction stream against an instruction-level model.
    for (int n = 0; n < 120; n++) begin
      int k, fw, dw, cyc, rq, we, rw, lat, e_rq, e_we, e_rw;
      logic [5:0] op, fn;
      bit is_mem;
`ifdef ILLEGAL_OP_TRAP_EN
      k = $urandom_range(0, 3);
`else
      k = $urandom_range(0, 4);
`endif
      fw = $urandom_range(0, 3); dw = $urandom_range(0, 3);
      fn = 6'($urandom);
      case (k)
        0: begin
          op = 6'h00;
          case ($urandom_range(0, 5))
            0: fn = 6'h20;
            1: fn = 6'h22;
            2: fn = 6'h24;
            3: fn = 6'h25;
            4: fn = 6'h2A;
            default: ;
          endcase
        end
        1: op = 6'h23;
        2: op = 6'h2B;
        3: op = 6'h04;
        default: begin
          op = 6'($urandom);
          while (op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04) op = 6'($urandom);
        end
      endcase
      is_mem = (k == 1 || k == 2);
      case (k)
        0: lat = 4;
        1: lat = 5;
        2: lat = 4;
        3: lat = 3;
        default: lat = 2;
      endcase
      lat  = lat + fw + (is_mem ? dw : 0);
      e_rq = fw + 1 + (is_mem ? dw + 1 : 0);
      e_we = (k == 2) ? dw + 1 : 0;
      e_rw = (k == 0 || k == 1) ? 1 : 0;
      run_instr(op, fn, fw, dw, cyc, rq, we, rw);
      chk($sformatf("rand%0d_latency", n), cyc, lat);
      chk($sformatf("rand%0d_req_cycles", n), rq, e_rq);
      chk($sformatf("rand%0d_we_cycles", n), we, e_we);
      chk($sformatf("rand%0d_rw_cycles", n), rw, e_rw);
      exp_cnt = exp_cnt + 1'b1;
    end

    // Unknown opcode 0x08.
    @(negedge clk); opcode = 6'h08; mem_ready = 1'b1;
    #1 chk("ill_fetch_state", state_out, 0);
    @(negedge clk); mem_ready = 1'b0;
    #1 chk("ill_decode_state", state_out, 1);
`ifdef ILLEGAL_OP_TRAP_EN
    chk("ill_decode_ctl", w_ctl, C_DEC);
    for (int t = 0; t < 3; t++) begin
      @(negedge clk); mem_ready = 1'b1;
      #1 chk("trap_state", state_out, 9);
      chk("trap_ctl", w_ctl, 0);
      chk("trap_count", instr_count, exp_cnt);
    end
`else
    chk("ill_decode_ctl", w_ctl, C_DEC | 17'd1);
    @(negedge clk);
    #1 chk("nop_state", state_out, 0);
    chk("nop_count", instr_count, exp_cnt + 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
